alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Initiator-side controller for the 2-bit trainer ALU.
- Accepts 8-bit instruction words over a valid/ready handshake and decodes them into op/operA/operB.
- Drives the ALU's input ports, waits out the ALU's registered latency, and captures the result.
- Presents the result with tag and zero flag on a valid/ready output channel.
- Sits between the instruction source (switch panel or sequencer) and the ALU, with one instruction in flight at a time.

Parameters:
- ALU_LATENCY, 1, clock edges from ALU inputs stable to alu_result updated; legal range is 1 or more.
- COUNT_W, 8, width of the completed-operation counter; used only when the optional feature is compiled in.

Ports:
- clk  in  1  system clock; all state is updated on the rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction word is present.
- instr_ready  out  1  controller can accept an instruction.
- instr  in  8  fields: [7:6] op, [5:4] operA, [3:2] operB, [1:0] tag.
- alu_op  out  2  registered opcode to the ALU.
- alu_operA  out  2  registered operand A to the ALU.
- alu_operB  out  2  registered operand B to the ALU.
- alu_result  in  2  ALU registered output.
- res_valid  out  1  result is held and valid.
- res_ready  in  1  consumer takes the result.
- res_data  out  2  captured ALU result.
- res_tag  out  2  tag of the instruction that produced res_data.
- res_zero  out  1  1 when res_data is 0.
- busy  out  1  1 in any state other than IDLE.

Behaviour:
- Clock and reset
  - One clock, clk. Reset is synchronous and active-high on rst.
  - rst is sampled on the clk edge and overrides every other event.
- Reset values
  - state = IDLE.
  - instr_ready = 1 (combinational from IDLE); all other outputs = 0.
  - Latency counter = 0.
- FSM states and transitions
  - IDLE: instr_ready = 1.
    - On an edge with instr_valid & instr_ready: register instr[7:6]→alu_op, [5:4]→alu_operA, [3:2]→alu_operB, and [1:0]→internal tag.
    - Load the latency counter with ALU_LATENCY-1 and go to EXEC.
  - EXEC: ALU inputs are stable. Decrement the counter each edge. On the edge where the counter is 0, go to CAPT.
    - EXEC lasts exactly ALU_LATENCY cycles.
  - CAPT: alu_result is valid. On the edge ending CAPT:
    - res_data ← alu_result, res_zero ← (alu_result == 0), res_tag ← tag.
    - res_valid ← 1; go to DONE.
  - DONE: res_valid = 1; res_data, res_tag and res_zero are held stable.
    - On an edge with res_ready = 1: res_valid ← 0 and go to IDLE. res_data, res_tag and res_zero keep their last values.
- Timing
  - With acceptance at edge E0, res_valid is first high after edge E(ALU_LATENCY+1).
  - Minimum issue interval is ALU_LATENCY+3 cycles.
- Handshake rules
  - instr_ready = (state == IDLE). It has no combinational dependence on instr_valid or res_ready.
  - instr_valid while not ready is ignored and nothing is latched; the source must hold its word.
  - res_ready while res_valid = 0 has no effect.
- alu_op, alu_operA and alu_operB change only on an acceptance edge or on reset. They hold their values otherwise.
- Arithmetic
  - ALU results are treated as modulo 4, with no carry or borrow.
  - Opcodes: 0 = B+A, 1 = B−A, 2 = B&A, 3 = ~A. The controller does not interpret opcodes; they are used only in the test plan.
- Boundary cases
  - rst mid-operation, in any state, discards the in-flight instruction and result. The next cycle is IDLE with reset values.
  - A result held indefinitely in DONE blocks new instructions with no loss.

Optional Feature:
- Macro: ALU_ISSUE_STATS_EN.
- Defined:
  - Adds output port op_count [COUNT_W-1:0], reset to 0.
  - Increments on each DONE→IDLE transfer (res_valid & res_ready) and wraps at 2^COUNT_W.
- Undefined: no op_count port, no counter logic, and all other behaviour is identical.

Decomposition:
- Shared package alu_pkg contains:
  - Opcode constants OP_ADD=0, OP_SUB=1, OP_AND=2, OP_NOT=3.
  - Instruction field position constants.
  - FSM state encoding: IDLE, EXEC, CAPT, DONE.
- The ALU uses the same opcode constants.
- No sub-module; the FSM, latency counter and stats counter are all small enough for a single module.

Test Plan:
- ADD: instr = 8'h1B (op0, A=1, B=2, tag 3) with res_ready held 1 → exactly one res_valid pulse, 2 cycles after acceptance (ALU_LATENCY = 1), with res_data = 3, res_tag = 3, res_zero = 0.
- SUB to zero: instr = 8'h54 (op1, A=1, B=1, tag 0) → res_data = 0, res_zero = 1.
- SUB wrap: instr = 8'h66 (op1, A=2, B=1, tag 2) → res_data = 3, res_tag = 2.
- NOT with backpressure: instr = 8'hE1 (op3, A=2, B=0) with res_ready low for 5 cycles → res_valid and res_data = 1 stay stable, instr_ready = 0 throughout, and a second instr_valid is not accepted. Raise res_ready → IDLE on the next edge.
- Reset mid-operation: assert rst for 1 cycle while in EXEC → next cycle busy = 0, res_valid = 0, all outputs 0, and no result is emitted later. Repeat with ALU_LATENCY = 3 and check that res_valid rises 4 cycles after acceptance.
- ALU_ISSUE_STATS_EN with COUNT_W = 2: complete 5 operations → op_count reads 1,2,3,0,1 after each handshake.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, instruction field positions and controller states
// The ALU and the issue controller both decode against these definitions.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_NOT = 2'd3;

  localparam int OP_MSB  = 7;
  localparam int OP_LSB  = 6;
  localparam int A_MSB   = 5;
  localparam int A_LSB   = 4;
  localparam int B_MSB   = 3;
  localparam int B_LSB   = 2;
  localparam int TAG_MSB = 1;
  localparam int TAG_LSB = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    DONE = 2'd3
  } state_e;

  // Modulo-4 reference behaviour of the trainer ALU.
  function automatic logic [1:0] alu_eval(input logic [1:0] op, input logic [1:0] a,
                                          input logic [1:0] b);
    case (op)
      OP_ADD:  return b + a;
      OP_SUB:  return b - a;
      OP_AND:  return b & a;
      default: return ~a;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - instruction, ALU and result channels of the issue controller
// master = instruction source, ALU and result consumer; slave = the controller.
interface alu_issue_ctrl_if;

  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr;
  logic [1:0] alu_op;
  logic [1:0] alu_operA;
  logic [1:0] alu_operB;
  logic [1:0] alu_result;
  logic       res_valid;
  logic       res_ready;
  logic [1:0] res_data;
  logic [1:0] res_tag;
  logic       res_zero;
  logic       busy;

  modport master (
    output instr_valid, instr, alu_result, res_ready,
    input  instr_ready, alu_op, alu_operA, alu_operB,
    input  res_valid, res_data, res_tag, res_zero, busy
  );

  modport slave (
    input  instr_valid, instr, alu_result, res_ready,
    output instr_ready, alu_op, alu_operA, alu_operB,
    output res_valid, res_data, res_tag, res_zero, busy
  );

endinterface

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - one-in-flight issue controller for the 2-bit trainer ALU
// Optional completed-operation counter op_count under macro ALU_ISSUE_STATS_EN.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int ALU_LATENCY = 1,
  parameter int COUNT_W     = 8
) (
  input  logic clk,
  input  logic rst,
  alu_issue_ctrl_if.slave bus
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [COUNT_W-1:0] op_count
`endif
);

  if (ALU_LATENCY < 1 || COUNT_W < 1) begin : g_bad_param
    $error("alu_issue_ctrl: ALU_LATENCY and COUNT_W must be at least 1");
  end

  localparam int CNT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(ALU_LATENCY - 1);

  state_e           state_q;
  logic [CNT_W-1:0] lat_cnt_q;
  logic [CNT_W-1:0] lat_cnt_d;
  logic [1:0]       op_q, opa_q, opb_q, tag_q;
  logic [1:0]       res_data_q, res_tag_q;
  logic             res_zero_q, res_valid_q;
`ifdef ALU_ISSUE_STATS_EN
  logic [COUNT_W-1:0] op_count_q;
  assign op_count = op_count_q;
`endif

  assign lat_cnt_d = lat_cnt_q - 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lat_cnt_q   <= '0;
      op_q        <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      tag_q       <= '0;
      res_data_q  <= '0;
      res_tag_q   <= '0;
      res_zero_q  <= 1'b0;
      res_valid_q <= 1'b0;
`ifdef ALU_ISSUE_STATS_EN
      op_count_q  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (bus.instr_valid) begin
          op_q      <= bus.instr[OP_MSB:OP_LSB];
          opa_q     <= bus.instr[A_MSB:A_LSB];
          opb_q     <= bus.instr[B_MSB:B_LSB];
          tag_q     <= bus.instr[TAG_MSB:TAG_LSB];
          lat_cnt_q <= LAT_LOAD;
          state_q   <= EXEC;
        end
        // Counter reaching zero marks the edge on which alu_result becomes current.
        EXEC: if (lat_cnt_q == '0) state_q <= CAPT;
              else lat_cnt_q <= lat_cnt_d;
        CAPT: begin
          res_data_q  <= bus.alu_result;
          res_zero_q  <= (bus.alu_result == 2'd0);
          res_tag_q   <= tag_q;
          res_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: if (bus.res_ready) begin
          res_valid_q <= 1'b0;
          state_q     <= IDLE;
`ifdef ALU_ISSUE_STATS_EN
          op_count_q  <= op_count_q + 1'b1;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.instr_ready = (state_q == IDLE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.alu_op      = op_q;
  assign bus.alu_operA   = opa_q;
  assign bus.alu_operB   = opb_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_data    = res_data_q;
  assign bus.res_tag     = res_tag_q;
  assign bus.res_zero    = res_zero_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - scoreboard bench for alu_issue_ctrl at ALU latency 1 and 3
// Stimulus pushes expected {data,tag,zero}; per-DUT monitors pop on each result handshake.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_issue_ctrl_if if1 ();
  alu_issue_ctrl_if if3 ();

  bit         cur = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_instr = 8'h00;
  logic       s_rr = 1'b0;

  assign if1.instr_valid = s_valid & ~cur;
  assign if3.instr_valid = s_valid & cur;
  assign if1.instr       = s_instr;
  assign if3.instr       = s_instr;
  assign if1.res_ready   = s_rr;
  assign if3.res_ready   = s_rr;

`ifdef ALU_ISSUE_STATS_EN
  logic [1:0] cnt1;
  logic [7:0] cnt3;
`endif

  alu_issue_ctrl #(.ALU_LATENCY(1), .COUNT_W(2)) u_dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave)
`ifdef ALU_ISSUE_STATS_EN
    , .op_count(cnt1)
`endif
  );

  alu_issue_ctrl #(.ALU_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst), .bus(if3.slave)
`ifdef ALU_ISSUE_STATS_EN
    , .op_count(cnt3)
`endif
  );

  // ALU models: registered result after 1 and 3 edges respectively.
  logic [1:0] p1 = 2'd0, p2 = 2'd0;
  initial begin
    if1.alu_result = 2'd0;
    if3.alu_result = 2'd0;
  end
  always @(posedge clk) if1.alu_result <= alu_eval(if1.alu_op, if1.alu_operA, if1.alu_operB);
  always @(posedge clk) begin
    p1 <= alu_eval(if3.alu_op, if3.alu_operA, if3.alu_operB);
    p2 <= p1;
    if3.alu_result <= p2;
  end

  logic       m_ready, m_valid, m_busy, m_zero;
  logic [1:0] m_data, m_tag, m_op, m_a, m_b;
  assign m_ready = cur ? if3.instr_ready : if1.instr_ready;
  assign m_valid = cur ? if3.res_valid   : if1.res_valid;
  assign m_busy  = cur ? if3.busy        : if1.busy;
  assign m_zero  = cur ? if3.res_zero    : if1.res_zero;
  assign m_data  = cur ? if3.res_data    : if1.res_data;
  assign m_tag   = cur ? if3.res_tag     : if1.res_tag;
  assign m_op    = cur ? if3.alu_op      : if1.alu_op;
  assign m_a     = cur ? if3.alu_operA   : if1.alu_operA;
  assign m_b     = cur ? if3.alu_operB   : if1.alu_operB;

  int n_cmp = 0;
  int n_fail = 0;
  logic [4:0] q1[$];
  logic [4:0] q3[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [4:0] e1, e3;
`ifdef ALU_ISSUE_STATS_EN
  logic [1:0] exp_cnt = 2'd0;
  bit         cnt_pend = 1'b0;
`endif

  always @(negedge clk) begin
`ifdef ALU_ISSUE_STATS_EN
    if (rst) begin
      exp_cnt  = 2'd0;
      cnt_pend = 1'b0;
    end else if (cnt_pend) begin
      chk("op_count", {30'd0, cnt1}, {30'd0, exp_cnt});
      cnt_pend = 1'b0;
    end
`endif
    if (if1.res_valid && if1.res_ready) begin
      if (q1.size() == 0) chk("unexpected_result_lat1", {27'd0, if1.res_data, if1.res_tag, if1.res_zero}, 32'hdead);
      else begin
        e1 = q1.pop_front();
        chk("result_lat1", {27'd0, if1.res_data, if1.res_tag, if1.res_zero}, {27'd0, e1});
      end
`ifdef ALU_ISSUE_STATS_EN
      exp_cnt  = exp_cnt + 2'd1;
      cnt_pend = 1'b1;
`endif
    end
  end

  always @(negedge clk) begin
    if (if3.res_valid && if3.res_ready) begin
      if (q3.size() == 0) chk("unexpected_result_lat3", {27'd0, if3.res_data, if3.res_tag, if3.res_zero}, 32'hdead);
      else begin
        e3 = q3.pop_front();
        chk("result_lat3", {27'd0, if3.res_data, if3.res_tag, if3.res_zero}, {27'd0, e3});
      end
    end
  end

  task automatic push(input logic [1:0] d, input logic [1:0] t, input logic z);
    if (cur) q3.push_back({d, t, z});
    else     q1.push_back({d, t, z});
  endtask

  task automatic wait_ready();
    int k = 0;
    @(negedge clk);
    while (!m_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("wait_ready", {31'd0, m_ready}, 32'd1);
  endtask

  // Returns 1 time unit after the acceptance edge.
  task automatic issue(input logic [7:0] w);
    wait_ready();
    @(posedge clk); #1;
    s_valid = 1'b1;
    s_instr = w;
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic time_valid(input string name, input int expk);
    int k = 0;
    @(negedge clk);
    while (!m_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk(name, k, expk);
  endtask

  task automatic check_reset_state(input string name);
    chk({name, "_ready"}, {31'd0, m_ready}, 32'd1);
    chk({name, "_busy"}, {31'd0, m_busy}, 32'd0);
    chk({name, "_outs"}, {19'd0, m_valid, m_data, m_tag, m_zero, m_op, m_a, m_b}, 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset_lat1");
    cur = 1'b1; #1;
    check_reset_state("reset_lat3");
    cur = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    s_rr = 1'b1;
    push(2'd3, 2'd3, 1'b0);
    issue(8'h1B);
    chk("add_fields", {26'd0, m_op, m_a, m_b}, {26'd0, 6'b00_01_10});
    chk("add_busy", {31'd0, m_busy}, 32'd1);
    chk("add_not_ready", {31'd0, m_ready}, 32'd0);
    time_valid("add_latency", 2);
    @(negedge clk);
    chk("add_single_pulse", {31'd0, m_valid}, 32'd0);

    push(2'd0, 2'd0, 1'b1);
    issue(8'h54);
    time_valid("sub_zero_latency", 2);

    push(2'd3, 2'd2, 1'b0);
    issue(8'h66);
    time_valid("sub_wrap_latency", 2);

    wait_ready();
    @(posedge clk); #1;
    s_rr = 1'b0;
    push(2'd1, 2'd1, 1'b0);
    issue(8'hE1);
    time_valid("not_latency", 2);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      s_valid = 1'b1;
      s_instr = 8'h1B;
      @(negedge clk);
      chk("stall_valid", {31'd0, m_valid}, 32'd1);
      chk("stall_data", {30'd0, m_data}, 32'd1);
      chk("stall_ready", {31'd0, m_ready}, 32'd0);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_rr = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_ready", {31'd0, m_ready}, 32'd1);
    chk("bp_idle_busy", {31'd0, m_busy}, 32'd0);
    chk("bp_valid_low", {31'd0, m_valid}, 32'd0);
    chk("bp_held", {27'd0, m_data, m_tag, m_zero}, {27'd0, 5'b01_01_0});
    chk("bp_no_latch", {26'd0, m_op, m_a, m_b}, {26'd0, 6'b11_10_00});

    push(2'd1, 2'd3, 1'b0);
    issue(8'hB7);
    time_valid("and_latency", 2);

    issue(8'h1B);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("midop_lat1");
    repeat (6) @(negedge clk);

    @(posedge clk); #1;
    cur = 1'b1;
    issue(8'h1B);
    @(posedge clk); #1;
    chk("lat3_exec_busy", {31'd0, m_busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("midop_lat3");
    repeat (8) @(negedge clk);

    push(2'd3, 2'd3, 1'b0);
    issue(8'h1B);
    time_valid("lat3_latency", 4);
    @(negedge clk);
    chk("lat3_single_pulse", {31'd0, m_valid}, 32'd0);
    push(2'd0, 2'd0, 1'b1);
    issue(8'h54);
    time_valid("lat3_sub_latency", 4);

    repeat (5) @(negedge clk);
    chk("q1_drained", q1.size(), 32'd0);
    chk("q3_drained", q3.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
